window_controller: RTL and testbench
====================================

# window_controller

Sequencing controller for the `window_buffer` sliding-window line buffer. It accepts a raster-order pixel stream over a valid/ready handshake and drives the buffer's `enable_i`. It tracks the row/column of each accepted pixel and flags exactly those cycles in which the buffer's `window_o` holds a complete, stride-aligned WINDOW_SIZE×WINDOW_SIZE window, holding the window stable under downstream backpressure. It sits between the pixel source and the convolution datapath, with `window_buffer` instantiated alongside it.

## Interface
- `LINE_LENGTH`, 4: pixels per image row; must equal the buffer's LINE_LENGTH.
- `NUM_LINES`, 4: rows per frame.
- `WINDOW_SIZE`, 3: window edge K; must equal the buffer's WINDOW_SIZE; 1 ≤ K ≤ min(LINE_LENGTH, NUM_LINES).
- `STRIDE`, 1: window step S in both directions, ≥1.
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `start_i` in 1: begin a frame; sampled only in IDLE.
- `pixel_valid_i` in 1: source has a pixel on the buffer's `data_i`.
- `pixel_ready_o` out 1: controller accepts a pixel this cycle.
- `buf_enable_o` out 1: to buffer `enable_i`; = `pixel_valid_i & pixel_ready_o` (combinational).
- `window_valid_o` out 1: buffer `window_o` holds a valid window.
- `window_ready_i` in 1: downstream consumes the window this cycle.
- `buffer_full_o` out 1: (K-1)·LINE_LENGTH+K pixels accepted this frame.
- `row_o` out clog2(NUM_LINES): row of the last accepted pixel.
- `col_o` out clog2(LINE_LENGTH): column of the last accepted pixel.
- `busy_o` out 1: state ≠ IDLE.
- `done_o` out 1: one-cycle pulse at frame completion.

## Operation
- States: IDLE, STREAM, FLUSH.
  - IDLE: `pixel_ready_o`=0. On `start_i`, clear counters and `buffer_full_o`, then go to STREAM.
  - STREAM: `pixel_ready_o = !window_valid_o | window_ready_i`.
  - FLUSH: entered after the last pixel is accepted; `pixel_ready_o`=0. Wait until `window_valid_o` is low, or high with `window_ready_i`. Then pulse `done_o` and go to IDLE.
- Transfer: a pixel is accepted on a cycle with `pixel_valid_i & pixel_ready_o`. The buffer shifts on that edge.
- Position counters: col increments per accepted pixel and wraps at LINE_LENGTH-1 to 0, incrementing row. Accepting the pixel at (NUM_LINES-1, LINE_LENGTH-1) moves the state to FLUSH. `row_o`/`col_o` show the accepted pixel's position from the next cycle.
- Window qualification: an accepted pixel at (r,c) qualifies iff:
  - r ≥ K-1 and c ≥ K-1;
  - (r-K+1) mod S = 0 and (c-K+1) mod S = 0.
  - Modulo is implemented with phase counters, not dividers.
- Window count per frame is ((LINE_LENGTH-K)/S+1)·((NUM_LINES-K)/S+1), using integer division.
- `window_valid_o` is registered:
  - it sets on the edge that accepts a qualifying pixel;
  - it clears on a cycle with `window_ready_i` and no new qualifying accept;
  - if a consume and a qualifying accept occur in the same cycle, it stays 1 (next window).
- `buffer_full_o` sets when the accepted-pixel count reaches (K-1)·LINE_LENGTH+K. It is sticky until the next `start_i` or reset.
- `start_i` outside IDLE is ignored. `pixel_valid_i` in IDLE/FLUSH is ignored, and no enable is issued.
- `window_ready_i` without `window_valid_o` has no effect.
- Buffer contents are never cleared. Stale data from a previous frame is masked by qualification.

## Timing
- Reset (synchronous, `rst_i`=1 at an edge): state IDLE; `pixel_ready_o`, `window_valid_o`, `buffer_full_o`, `busy_o`, `done_o` all 0; `row_o`, `col_o` 0.
- Reset mid-frame aborts: no `done_o`, and any pending window is dropped.
- `busy_o` rises the cycle after `start_i` is seen in IDLE.
- Latency: qualifying pixel accepted at edge t → `window_valid_o`=1 during cycle t+1, with the matching `window_o` stable.
- Backpressure: while `window_valid_o`=1 and `window_ready_i`=0, `pixel_ready_o`=0 and `buf_enable_o`=0. The window holds unchanged.
- Throughput: one pixel per cycle with `window_ready_i` held high.
- `done_o` asserts in the cycle FLUSH exits. `busy_o` falls in the following cycle.
- Minimum frame time with no stalls: LINE_LENGTH·NUM_LINES+2 cycles from `start_i` to `done_o`.
- K=1 with S=1: every accepted pixel qualifies.

## Test plan
- Reset then idle: with `pixel_valid_i`=1 and no start, all outputs stay 0 and `buf_enable_o`=0 for 20 cycles.
- Basic frame (4×4, K=3, S=1), pixels 0x00..0x0F, `window_ready_i`=1:
  - `buffer_full_o` rises after the 11th pixel;
  - exactly 4 windows, after pixels 0x0A, 0x0B, 0x0E, 0x0F;
  - first window = 00,01,02,04,05,06,08,09,0A;
  - `done_o` one cycle.
- Backpressure: same frame with `window_ready_i`=0 for 5 cycles at the first window → `window_valid_o` and `window_o` held, `pixel_ready_o`=0, no enable pulses; stream resumes on release, still 4 windows.
- Stride (LINE_LENGTH=6, NUM_LINES=6, K=3, S=2): windows only at (r,c) ∈ {2,4}×{2,4}, 4 windows total.
- Source gaps: `pixel_valid_i` toggled randomly → counters advance only on accepts, and window positions are identical to the gap-free run.
- Reset mid-frame after 7 pixels, then restart → counters restart at 0, `buffer_full_o`=0 until 11 new pixels, no windows from stale data before pixel 0x0A.

Source files
------------

// File: rtl/window_controller.sv
// Sequencing controller for window_buffer: accepts a raster pixel stream, drives the
// buffer shift enable and flags cycles where the buffer holds a stride-aligned window.
module window_controller #(
  parameter int unsigned LINE_LENGTH = 4,
  parameter int unsigned NUM_LINES   = 4,
  parameter int unsigned WINDOW_SIZE = 3,
  parameter int unsigned STRIDE      = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic pixel_valid_i,
  output logic pixel_ready_o,
  output logic buf_enable_o,
  output logic window_valid_o,
  input  logic window_ready_i,
  output logic buffer_full_o,
  output logic [((NUM_LINES > 1) ? $clog2(NUM_LINES) : 1)-1:0]     row_o,
  output logic [((LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1)-1:0] col_o,
  output logic busy_o,
  output logic done_o
);

  localparam int unsigned RW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int unsigned CW = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam int unsigned SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [SW-1:0] col_phase;
  logic [SW-1:0] row_phase;
  logic          accept;
  logic          last_col;
  logic          last_pixel;
  logic          qualify;
  logic          fill_point;

  // col/row/phase describe the pixel that the next accept will carry
  assign pixel_ready_o = (state == STREAM) && (!window_valid_o || window_ready_i);
  assign buf_enable_o  = pixel_valid_i && pixel_ready_o;
  assign accept        = buf_enable_o;
  assign last_col      = (col == CW'(LINE_LENGTH - 1));
  assign last_pixel    = last_col && (row == RW'(NUM_LINES - 1));
  assign fill_point    = (col == CW'(WINDOW_SIZE - 1)) && (row == RW'(WINDOW_SIZE - 1));
  assign qualify       = (col >= CW'(WINDOW_SIZE - 1)) && (row >= RW'(WINDOW_SIZE - 1)) &&
                         (col_phase == '0) && (row_phase == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      col            <= '0;
      row            <= '0;
      col_phase      <= '0;
      row_phase      <= '0;
      window_valid_o <= 1'b0;
      buffer_full_o  <= 1'b0;
      row_o          <= '0;
      col_o          <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      done_o <= 1'b0;

      // a qualifying accept replaces a consumed window in the same cycle
      if (accept && qualify) begin
        window_valid_o <= 1'b1;
      end else if (window_ready_i) begin
        window_valid_o <= 1'b0;
      end

      if (accept) begin
        row_o <= row;
        col_o <= col;
        if (fill_point) begin
          buffer_full_o <= 1'b1;
        end
        if (last_col) begin
          col       <= '0;
          col_phase <= '0;
          row       <= last_pixel ? '0 : row + 1'b1;
          if (row >= RW'(WINDOW_SIZE - 1)) begin
            row_phase <= (row_phase == SW'(STRIDE - 1)) ? '0 : row_phase + 1'b1;
          end else begin
            row_phase <= '0;
          end
        end else begin
          col <= col + 1'b1;
          if (col >= CW'(WINDOW_SIZE - 1)) begin
            col_phase <= (col_phase == SW'(STRIDE - 1)) ? '0 : col_phase + 1'b1;
          end else begin
            col_phase <= '0;
          end
        end
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            state         <= STREAM;
            busy_o        <= 1'b1;
            col           <= '0;
            row           <= '0;
            col_phase     <= '0;
            row_phase     <= '0;
            row_o         <= '0;
            col_o         <= '0;
            buffer_full_o <= 1'b0;
          end else if (done_o) begin
            busy_o <= 1'b0;
          end
        end
        STREAM: begin
          if (accept && last_pixel) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          // drain the final window before declaring the frame done
          if (!window_valid_o || window_ready_i) begin
            done_o <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_window_controller.sv
// Directed bench for window_controller: a 4x4/K3/S1 instance and a 6x6/K3/S2 instance
// driven from shared inputs, checked against hand-computed window positions and timing.
module tb_window_controller;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;
  logic pixel_valid;
  logic window_ready;

  logic       rdy_a, en_a, wv_a, full_a, busy_a, done_a;
  logic [1:0] row_a, col_a;
  logic       rdy_b, en_b, wv_b, full_b, busy_b, done_b;
  logic [2:0] row_b, col_b;

  bit sel;
  logic o_ready, o_en, o_wvalid, o_full, o_busy, o_done;
  int   o_row, o_col;

  int total = 0;
  int bad   = 0;

  int win_pos[$];
  int full_at, done_cnt, acc_cnt, frame_len, viol, busy_at_done, busy_after;

  always #5 clk = ~clk;

  window_controller #(.LINE_LENGTH(4), .NUM_LINES(4), .WINDOW_SIZE(3), .STRIDE(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .pixel_valid_i(pixel_valid),
    .pixel_ready_o(rdy_a), .buf_enable_o(en_a), .window_valid_o(wv_a),
    .window_ready_i(window_ready), .buffer_full_o(full_a), .row_o(row_a), .col_o(col_a),
    .busy_o(busy_a), .done_o(done_a)
  );

  window_controller #(.LINE_LENGTH(6), .NUM_LINES(6), .WINDOW_SIZE(3), .STRIDE(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .pixel_valid_i(pixel_valid),
    .pixel_ready_o(rdy_b), .buf_enable_o(en_b), .window_valid_o(wv_b),
    .window_ready_i(window_ready), .buffer_full_o(full_b), .row_o(row_b), .col_o(col_b),
    .busy_o(busy_b), .done_o(done_b)
  );

  assign o_ready  = sel ? rdy_b  : rdy_a;
  assign o_en     = sel ? en_b   : en_a;
  assign o_wvalid = sel ? wv_b   : wv_a;
  assign o_full   = sel ? full_b : full_a;
  assign o_busy   = sel ? busy_b : busy_a;
  assign o_done   = sel ? done_b : done_a;
  assign o_row    = sel ? int'(row_b) : int'(row_a);
  assign o_col    = sel ? int'(col_b) : int'(col_a);

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One frame on the selected instance; records window positions (r*line_len+c) on consume
  task automatic run_frame(input bit use_b, input int line_len, input int npix,
                           input bit gaps, input int stall_len, input int hold_pos);
    int  stall_left;
    bit  stalling;
    stall_left = stall_len;
    win_pos.delete();
    full_at = -1; done_cnt = 0; acc_cnt = 0; frame_len = -1; viol = 0;
    busy_at_done = -1; busy_after = -1;
    sel = use_b;
    @(posedge clk); #1;
    start_a = !use_b; start_b = use_b; pixel_valid = 1'b1; window_ready = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    for (int i = 1; i < 400; i++) begin
      pixel_valid = (acc_cnt < npix) && (!gaps || ($urandom_range(0, 1) == 1));
      if (o_wvalid && stall_left > 0) begin
        window_ready = 1'b0;
        stall_left--;
        stalling = 1'b1;
      end else begin
        window_ready = 1'b1;
        stalling = 1'b0;
      end
      @(negedge clk);
      if (stalling && (o_ready || o_en || !o_wvalid || (o_row * line_len + o_col) != hold_pos))
        viol++;
      if (o_en != (pixel_valid && o_ready)) viol++;
      if (o_full && full_at < 0) full_at = acc_cnt;
      if (o_wvalid && window_ready) win_pos.push_back(o_row * line_len + o_col);
      if (o_en) acc_cnt++;
      if (o_done) begin
        done_cnt++;
        if (frame_len < 0) begin
          frame_len = i;
          busy_at_done = int'(o_busy);
        end
      end
      if (frame_len >= 0 && i == frame_len + 1) begin
        busy_after = int'(o_busy);
        break;
      end
      @(posedge clk); #1;
    end
    pixel_valid = 1'b0;
    window_ready = 1'b1;
  endtask

  task automatic check_windows(input string tag, input int e0, input int e1,
                               input int e2, input int e3);
    int exp_pos[4];
    int got;
    exp_pos = '{e0, e1, e2, e3};
    check({tag, "_nwin"}, win_pos.size(), 4);
    for (int k = 0; k < 4; k++) begin
      got = (k < win_pos.size()) ? win_pos[k] : -1;
      check({tag, "_win"}, got, exp_pos[k]);
    end
  endtask

  initial begin
    int idle_viol;
    int cnt;
    sel = 1'b0;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; pixel_valid = 1'b1; window_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ready", int'(o_ready), 0);
    check("rst_en", int'(o_en), 0);
    check("rst_wvalid", int'(o_wvalid), 0);
    check("rst_full", int'(o_full), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_row", o_row, 0);
    check("rst_col", o_col, 0);

    // idle with a valid source and no start: nothing moves
    idle_viol = 0;
    window_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_ready || o_en || o_wvalid || o_full || o_busy || o_done || o_row != 0 || o_col != 0)
        idle_viol++;
    end
    check("idle_quiet", idle_viol, 0);
    pixel_valid = 1'b0;

    // basic 4x4 frame
    run_frame(1'b0, 4, 16, 1'b0, 0, 0);
    check("basic_full_at", full_at, 11);
    check_windows("basic", 10, 11, 14, 15);
    check("basic_done", done_cnt, 1);
    check("basic_len", frame_len, 18);
    check("basic_busy_done", busy_at_done, 1);
    check("basic_busy_after", busy_after, 0);
    check("basic_acc", acc_cnt, 16);
    check("basic_proto", viol, 0);

    // 5-cycle backpressure at the first window
    run_frame(1'b0, 4, 16, 1'b0, 5, 10);
    check_windows("stall", 10, 11, 14, 15);
    check("stall_hold", viol, 0);
    check("stall_len", frame_len, 23);
    check("stall_done", done_cnt, 1);

    // randomly gapped source
    run_frame(1'b0, 4, 16, 1'b1, 0, 0);
    check_windows("gaps", 10, 11, 14, 15);
    check("gaps_acc", acc_cnt, 16);
    check("gaps_full_at", full_at, 11);
    check("gaps_proto", viol, 0);

    // 6x6, K=3, S=2
    run_frame(1'b1, 6, 36, 1'b0, 0, 0);
    check_windows("stride", 14, 16, 26, 28);
    check("stride_full_at", full_at, 15);
    check("stride_len", frame_len, 38);
    check("stride_done", done_cnt, 1);

    // reset after 7 pixels, then a fresh frame
    sel = 1'b0;
    @(posedge clk); #1;
    start_a = 1'b1; pixel_valid = 1'b1; window_ready = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_en) cnt++;
      if (cnt == 7) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check("mid_pos", o_row * 4 + o_col, 6);
    check("mid_busy", int'(o_busy), 1);
    rst = 1'b1; pixel_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_row", o_row, 0);
    check("mid_rst_col", o_col, 0);
    check("mid_rst_busy", int'(o_busy), 0);
    check("mid_rst_wvalid", int'(o_wvalid), 0);
    idle_viol = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (o_done || o_ready) idle_viol++;
    end
    check("mid_no_done", idle_viol, 0);
    run_frame(1'b0, 4, 16, 1'b0, 0, 0);
    check("restart_full_at", full_at, 11);
    check_windows("restart", 10, 11, 14, 15);
    check("restart_done", done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
